// File: rtl/arbitro_somador.sv
// arbitro_somador: two requesters share one registered W-bit adder.
// A round-robin arbiter grants one request at a time. Each transaction
// passes through IDLE (grant) -> CALC (add) -> RESP (one-cycle ack) and
// then returns to IDLE.
module arbitro_somador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] res,
  output logic         cout,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;

  // Round-robin pointer: names the requester that wins a tie.
  logic         ptr;
  // ID of the requester whose operation is in flight.
  logic         gnt_id;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  // Decoded controls, produced by the next-state logic.
  logic         grant_sel;
  logic         load_ops;
  logic         load_res;
  logic [W:0]   sum;

  // Widen both operands by one bit so the carry lands in the MSB.
  assign sum = {1'b0, op_a} + {1'b0, op_b};

  // State register. It is cleared at once when rst rises, so an
  // operation that was in flight is dropped and never acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses <= so that every flop samples its
      // pre-edge value, regardless of block or statement order.
      state <= state_nx;
    end
  end

  // Next-state logic, arbitration decision and datapath controls.
  always_comb begin
    // NOTE: every output gets a default first. A path that leaves a
    // signal unassigned would infer a latch.
    state_nx  = state;
    grant_sel = 1'b0;
    load_ops  = 1'b0;
    load_res  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the pointer decides; a lone requester wins
          // outright whatever the pointer says.
          if (req0 && req1) grant_sel = ptr;
          else              grant_sel = req1;
          load_ops = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        load_res = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Capture the grant: the winner's ID and operands, and pass
  // priority to the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= 1'b0;
      gnt_id <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (load_ops) begin
      ptr    <= ~grant_sel;
      gnt_id <= grant_sel;
      op_a   <= grant_sel ? a1 : a0;
      op_b   <= grant_sel ? b1 : b0;
    end
  end

  // Result register. It keeps its value until the next CALC->RESP edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res  <= '0;
      cout <= 1'b0;
    end else if (load_res) begin
      {cout, res} <= sum;
    end
  end

  // Ack is decoded from RESP, so at most one ack is high at a time and
  // it lasts exactly one cycle.
  assign ack0 = (state == RESP) && (gnt_id == 1'b0);
  assign ack1 = (state == RESP) && (gnt_id == 1'b1);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_arbitro_somador.sv
// Directed bench for arbitro_somador (W = 4). All expected values are
// worked out by hand. Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point.
module tb_arbitro_somador;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] res;
  logic         cout;
  logic         busy;

  int vectors;
  int miscompares;

  arbitro_somador #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .a0   (a0),
    .b0   (b0),
    .req1 (req1),
    .a1   (a1),
    .b1   (b1),
    .ack0 (ack0),
    .ack1 (ack1),
    .res  (res),
    .cout (cout),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against one expected value.
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge, then settle for 1 ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check both acks, and check that they never overlap.
  task automatic check_acks(input string tag, input logic e0, input logic e1);
    check({tag, ".ack0"}, {7'd0, ack0}, {7'd0, e0});
    check({tag, ".ack1"}, {7'd0, ack1}, {7'd0, e1});
    check({tag, ".no_overlap"}, {7'd0, ack0 & ack1}, 8'd0);
  endtask

  // Check the registered sum and its carry.
  task automatic check_res(input string tag, input logic [W-1:0] er, input logic ec);
    check({tag, ".res"}, {4'd0, res}, {4'd0, er});
    check({tag, ".cout"}, {7'd0, cout}, {7'd0, ec});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset state.
    #2;
    check("rst.busy", {7'd0, busy}, 8'd0);
    check_acks("rst", 1'b0, 1'b0);
    check_res("rst", 4'h0, 1'b0);
    tick();
    rst = 1'b0;

    // Single requester: 1 + 2 = 3. Ack comes 2 cycles after req.
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd2;
    tick();                                   // grant edge -> CALC
    check("single.busy_calc", {7'd0, busy}, 8'd1);
    check_acks("single.calc", 1'b0, 1'b0);
    tick();                                   // -> RESP
    check_acks("single.resp", 1'b1, 1'b0);
    check_res("single", 4'd3, 1'b0);
    tick();                                   // -> IDLE
    req0 = 1'b0;
    check_acks("single.after", 1'b0, 1'b0);
    check("single.idle_busy", {7'd0, busy}, 8'd0);

    // Overflow: F + 3 = 0x12, so res = 2 and cout = 1.
    req1 = 1'b1; a1 = 4'hF; b1 = 4'h3;
    tick();
    tick();
    check_acks("ovf.resp", 1'b0, 1'b1);
    check_res("ovf", 4'h2, 1'b1);
    tick();
    req1 = 1'b0;
    check_acks("ovf.after", 1'b0, 1'b0);
    check_res("ovf.hold", 4'h2, 1'b1);

    // Contention just after reset: pointer is 0, so requester 0 wins.
    rst = 1'b1;
    #1;
    check_res("rst2", 4'h0, 1'b0);
    rst = 1'b0;
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd1;
    tick();                                   // grant 0
    tick();                                   // RESP for 0
    check_acks("cont.first", 1'b1, 1'b0);
    check_res("cont.first", 4'd8, 1'b0);
    tick();                                   // IDLE; req1 still waiting
    req0 = 1'b0;
    check_acks("cont.idle", 1'b0, 1'b0);
    check("cont.idle_busy", {7'd0, busy}, 8'd0);
    tick();                                   // grant 1 -> CALC
    check("cont.calc_busy", {7'd0, busy}, 8'd1);
    check_acks("cont.calc", 1'b0, 1'b0);
    tick();                                   // RESP for 1, 3 cycles after ack0
    check_acks("cont.second", 1'b0, 1'b1);
    check_res("cont.second", 4'd4, 1'b0);
    tick();
    req1 = 1'b0;

    // Fairness: both held high, so grants must alternate 0,1,0,1.
    // The pointer is 0 here because the last grant went to requester 1.
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd2;        // 4
    req1 = 1'b1; a1 = 4'd6; b1 = 4'd1;        // 7
    for (int i = 0; i < 4; i++) begin
      tick();                                 // grant
      check_acks("fair.calc", 1'b0, 1'b0);
      tick();                                 // RESP
      if (i % 2 == 0) begin
        check_acks("fair.resp0", 1'b1, 1'b0);
        check_res("fair.res0", 4'd4, 1'b0);
      end else begin
        check_acks("fair.resp1", 1'b0, 1'b1);
        check_res("fair.res1", 4'd7, 1'b0);
      end
      tick();                                 // IDLE
      check_acks("fair.idle", 1'b0, 1'b0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("fair.end_busy", {7'd0, busy}, 8'd0);

    // Operand stability: a0 changes during CALC; the captured 1 is used.
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd4;
    tick();                                   // grant -> CALC
    a0 = 4'd7;
    tick();                                   // RESP
    check_acks("stab.resp", 1'b1, 1'b0);
    check_res("stab", 4'd5, 1'b0);
    tick();
    req0 = 1'b0;

    // Reset mid-operation: rst in CALC aborts the operation without an ack.
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd1;
    tick();                                   // grant -> CALC
    check("abort.calc_busy", {7'd0, busy}, 8'd1);
    rst  = 1'b1;
    req0 = 1'b0;
    #1;
    check("abort.busy", {7'd0, busy}, 8'd0);
    check_acks("abort.now", 1'b0, 1'b0);
    check_res("abort.now", 4'h0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_acks("abort.later", 1'b0, 1'b0);
    check("abort.later_busy", {7'd0, busy}, 8'd0);
    check_res("abort.later", 4'h0, 1'b0);

    // A fresh request after the aborted one completes normally: 2 + 3.
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
    tick();
    tick();
    check_acks("fresh.resp", 1'b1, 1'b0);
    check_res("fresh", 4'd5, 1'b0);
    tick();
    req0 = 1'b0;
    check_acks("fresh.after", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arbitro_somador.md
ARBITRO_SOMADOR -- requirements
Module: arbitro_somador

Interface
REQ-001 The block SHALL have parameter W, default 4: operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 asks for one addition.
REQ-005 The block SHALL have port a0, input, W bits: requester 0 operand A.
REQ-006 The block SHALL have port b0, input, W bits: requester 0 operand B.
REQ-007 The block SHALL have port req1, input, 1 bit: requester 1 asks for one addition.
REQ-008 The block SHALL have port a1, input, W bits: requester 1 operand A.
REQ-009 The block SHALL have port b1, input, W bits: requester 1 operand B.
REQ-010 The block SHALL have port ack0, output, 1 bit: result for requester 0 is valid this cycle.
REQ-011 The block SHALL have port ack1, output, 1 bit: result for requester 1 is valid this cycle.
REQ-012 The block SHALL have port res, output, W bits: registered sum, modulo 2^W.
REQ-013 The block SHALL have port cout, output, 1 bit: registered carry-out of the sum.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL implement the FSM states IDLE, CALC and RESP, encoded internally.
REQ-016 In IDLE, when no req is high at a rising edge, the FSM SHALL remain in IDLE.
REQ-017 In IDLE, when at least one req is high at a rising edge, the FSM SHALL register the selected requester's operands and ID and move to CALC.
REQ-018 In CALC, the FSM SHALL register {cout,res} = a + b at W+1-bit width at the next edge and move to RESP.
REQ-019 In RESP, ackN of the granted requester SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-020 Latency: if req is sampled at edge k, ack SHALL be high between edge k+2 and edge k+3.
REQ-021 At most one ack SHALL be high in any cycle, and no ack SHALL be high outside RESP.
REQ-022 Operands SHALL be captured only at the grant edge; later changes on aN/bN SHALL NOT affect that result.
REQ-023 res and cout SHALL hold their last value until the next CALC→RESP edge.
REQ-024 Arbitration SHALL be round-robin using a one-bit pointer to the higher-priority requester, with pointer = 0 after reset.
REQ-025 When both req are high in IDLE, the block SHALL grant the requester named by the pointer.
REQ-026 When only one req is high in IDLE, the block SHALL grant that requester regardless of the pointer.
REQ-027 On every grant, the pointer SHALL move to the requester that was not granted.
REQ-028 A requester SHALL hold req and its operands until its ack, and SHALL drop req in the cycle after ack.
REQ-029 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-030 A req that arrives while busy = 1 SHALL wait without being lost, and SHALL be granted at the next IDLE edge.
REQ-031 Overflow SHALL wrap: res = (a + b) mod 2^W, with cout = 1 exactly when a + b ≥ 2^W.

Reset
REQ-032 Asserting rst SHALL immediately force: state IDLE, ack0 = ack1 = 0, busy = 0, res = 0, cout = 0, pointer = 0, captured operands = 0.
REQ-033 If rst is asserted during CALC or RESP, the block SHALL abort the operation in progress and SHALL NOT emit any ack for it after rst is released.
REQ-034 After rst is released, the first grant SHALL be possible at the first rising edge at which rst is low.

Verification
REQ-035 The bench SHALL check single requester, W = 4: req0 with a0 = 1, b0 = 2 → ack0 pulses one cycle, 2 cycles later, with res = 3 and cout = 0; ack1 stays 0.
REQ-036 The bench SHALL check overflow: req1 with a1 = 4'hF, b1 = 4'h3 → ack1, res = 4'h2, cout = 1.
REQ-037 The bench SHALL check contention: req0 (5+3) and req1 (3+1) raised at the same edge after reset → ack0 first with res = 8, then, 3 cycles later, ack1 with res = 4.
REQ-038 The bench SHALL check fairness: req0 and req1 held high continuously, each re-presenting after its ack → grants alternate 0,1,0,1 and no ack overlaps.
REQ-039 The bench SHALL check operand stability: a0 changed from 1 to 7 in the CALC cycle → result uses the captured value 1.
REQ-040 The bench SHALL check reset mid-operation: rst pulsed in CALC → no ack, res = 0, busy = 0, and a fresh req0 afterwards completes normally.
